// File: rtl/stage_pipe_ctrl_pkg.sv
// Shared definitions for the stage_pipe_ctrl chain: mode encodings and the
// occupancy width helper.
package stage_pipe_ctrl_pkg;

   localparam int MODE_PIPE  = 0;
   localparam int MODE_MULTI = 1;

   function automatic int occ_w(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/stage_pipe_ctrl_pipe_slice.sv
// One register stage of the chain: a valid bit plus payload, with the
// ready chain computed locally so stages can be cascaded.
module pipe_slice #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             down_ready,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic load;

   assign ready = !valid | down_ready;
   assign load  = up_valid & ready & !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (flush)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (down_ready)
            valid <= 1'b0;
         if (load)
            data <= up_data;
      end
   end

endmodule

// File: rtl/stage_pipe_ctrl.sv
// Configurable-depth valid/ready stage chain with flush, occupancy report,
// retire strobe and saturating retire/stall counters.
module stage_pipe_ctrl
   import stage_pipe_ctrl_pkg::*;
#(
   parameter int STAGES = 4,
   parameter int WIDTH  = 64,
   parameter int MODE   = MODE_PIPE,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       flush,
   output logic                       inst_done,
   output logic [occ_w(STAGES)-1:0]   occupancy,
   output logic [CNT_W-1:0]           retire_cnt,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int OCC_W = occ_w(STAGES);

   // Handshake: a transfer occurs on an edge where valid and ready are both
   // high; valid never waits on ready, and a held valid keeps its data stable.
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] up_v;
   logic [STAGES-1:0] dn_r;
   logic [WIDTH-1:0]  up_d [STAGES];
   logic [WIDTH-1:0]  d    [STAGES];
   logic              in_fire;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign up_v[i] = in_fire;
         assign up_d[i] = in_data;
      end else begin : g_body
         assign up_v[i] = v[i-1];
         assign up_d[i] = d[i-1];
      end
      if (i == STAGES - 1) begin : g_tail
         assign dn_r[i] = out_ready;
      end else begin : g_link
         assign dn_r[i] = rdy[i+1];
      end

      pipe_slice #(.WIDTH(WIDTH)) u_slice (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .up_valid   (up_v[i]),
         .up_data    (up_d[i]),
         .down_ready (dn_r[i]),
         .ready      (rdy[i]),
         .valid      (v[i]),
         .data       (d[i])
      );
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++)
         occupancy = occupancy + OCC_W'(v[i]);
   end

   // Multi-cycle mode only reopens once the registered count is zero, so a
   // retire never admits a new token in the same cycle.
   always_comb begin
      in_ready = !flush & ((MODE == MODE_MULTI) ? (occupancy == '0) : rdy[0]);
   end

   assign in_fire   = in_valid & in_ready;
   assign out_valid = v[STAGES-1] & !flush;
   assign out_data  = d[STAGES-1];
   assign inst_done = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (inst_done && retire_cnt != {CNT_W{1'b1}})
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (in_valid && !in_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_stage_pipe_ctrl.sv
// Bench for stage_pipe_ctrl: a pipelined, a multi-cycle and a narrow-counter
// instance share one stimulus stream; scoreboards check every cycle.
module tb_stage_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;
   logic        flush;

   logic        in_ready_a, out_valid_a, inst_done_a;
   logic [15:0] out_data_a;
   logic [2:0]  occ_a;
   logic [31:0] ret_a, stall_a;

   logic        in_ready_b, out_valid_b, inst_done_b;
   logic [15:0] out_data_b;
   logic [2:0]  occ_b;
   logic [31:0] ret_b, stall_b;

   logic        in_ready_c, out_valid_c, inst_done_c;
   logic [15:0] out_data_c;
   logic [2:0]  occ_c;
   logic [3:0]  ret_c, stall_c;

   stage_pipe_ctrl #(.STAGES(4), .WIDTH(16), .MODE(0), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .flush(flush), .inst_done(inst_done_a),
      .occupancy(occ_a), .retire_cnt(ret_a), .stall_cnt(stall_a));

   stage_pipe_ctrl #(.STAGES(4), .WIDTH(16), .MODE(1), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .flush(flush), .inst_done(inst_done_b),
      .occupancy(occ_b), .retire_cnt(ret_b), .stall_cnt(stall_b));

   stage_pipe_ctrl #(.STAGES(4), .WIDTH(16), .MODE(0), .CNT_W(4)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
      .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
      .out_data(out_data_c), .flush(flush), .inst_done(inst_done_c),
      .occupancy(occ_c), .retire_cnt(ret_c), .stall_cnt(stall_c));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard state
   logic [15:0] qa [$];
   logic [15:0] qb [$];
   int          acc_a [$];
   int          acc_b [$];
   int          cyc = 0;
   int          ret_ma, stall_ma, ret_mc, stall_mc, ret_mb, stall_mb;
   bit          lat_chk = 0;
   bit          m1_phase = 0;
   int          last_acc_b = -1;
   int          last_done_b = -1;
   bit          hold_a;
   logic [15:0] hold_d_a;
   bit          rdy_a, rdy_b;
   int          t;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         qa.delete(); qb.delete(); acc_a.delete(); acc_b.delete();
         ret_ma = 0; stall_ma = 0; ret_mc = 0; stall_mc = 0; ret_mb = 0; stall_mb = 0;
         hold_a = 0;
      end else begin
         rdy_a = !flush && (qa.size() < 4 || out_ready);
         rdy_b = !flush && (qb.size() == 0);
         check("occ_a", occ_a, qa.size());
         check("occ_c", occ_c, qa.size());
         check("occ_b", occ_b, qb.size());
         check("ret_a", ret_a, ret_ma);
         check("stall_a", stall_a, stall_ma);
         check("ret_c", ret_c, ret_mc);
         check("stall_c", stall_c, stall_mc);
         check("ret_b", ret_b, ret_mb);
         check("stall_b", stall_b, stall_mb);
         check("in_ready_a", in_ready_a, rdy_a);
         check("in_ready_c", in_ready_c, rdy_a);
         check("in_ready_b", in_ready_b, rdy_b);
         check("done_a", inst_done_a, out_valid_a & out_ready);
         check("done_b", inst_done_b, out_valid_b & out_ready);
         if (flush) begin
            check("flush_ov_a", out_valid_a, 1'b0);
            check("flush_ov_b", out_valid_b, 1'b0);
         end
         if (hold_a && !flush) begin
            check("hold_v_a", out_valid_a, 1'b1);
            check("hold_d_a", out_data_a, hold_d_a);
         end
         if (out_valid_a) begin
            if (qa.size() == 0) check("spurious_a", out_valid_a, 1'b0);
            else check("data_a", out_data_a, qa[0]);
         end
         if (out_valid_c && qa.size() > 0) check("data_c", out_data_c, qa[0]);
         if (out_valid_b) begin
            if (qb.size() == 0) check("spurious_b", out_valid_b, 1'b0);
            else check("data_b", out_data_b, qb[0]);
         end

         if (in_valid && !rdy_a) begin
            stall_ma++;
            if (stall_mc != 15) stall_mc++;
         end
         if (in_valid && !rdy_b) stall_mb++;
         hold_a   = out_valid_a && !out_ready && !flush;
         hold_d_a = out_data_a;

         if (flush) begin
            qa.delete(); acc_a.delete(); qb.delete(); acc_b.delete();
         end else begin
            if (out_valid_a && out_ready && qa.size() > 0) begin
               void'(qa.pop_front());
               t = acc_a.pop_front();
               if (lat_chk) check("lat_a", cyc - t, 4);
               ret_ma++;
               if (ret_mc != 15) ret_mc++;
            end
            if (in_valid && rdy_a) begin
               qa.push_back(in_data);
               acc_a.push_back(cyc);
            end
            if (out_valid_b && out_ready && qb.size() > 0) begin
               void'(qb.pop_front());
               t = acc_b.pop_front();
               if (lat_chk) check("lat_b", cyc - t, 4);
               ret_mb++;
               if (m1_phase && last_done_b >= 0) check("done_period_b", cyc - last_done_b, 5);
               last_done_b = m1_phase ? cyc : -1;
            end
            if (in_valid && rdy_b) begin
               qb.push_back(in_data);
               acc_b.push_back(cyc);
               if (m1_phase && last_acc_b >= 0) check("acc_gap_b", cyc - last_acc_b, 5);
               last_acc_b = m1_phase ? cyc : -1;
            end
         end
         if (!m1_phase) begin
            last_acc_b  = -1;
            last_done_b = -1;
         end
      end
   end

   // driver
   task automatic step(input bit v, input logic [15:0] d, input bit ordy, input bit fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, ordy, 1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid_a, 1'b0);
      check("rst_out_data", out_data_a, 16'h0);
      check("rst_done", inst_done_a, 1'b0);
      check("rst_occ", occ_a, 3'd0);
      check("rst_in_ready_a", in_ready_a, 1'b1);
      check("rst_in_ready_b", in_ready_b, 1'b1);
      check("rst_ret", ret_a, 32'd0);
      rst = 1'b1;

      // four back-to-back tokens, no backpressure
      lat_chk = 1;
      for (int i = 0; i < 4; i++) step(1'b1, 16'h11 + 16'(i), 1'b1, 1'b0);
      idle(8, 1'b1);
      check("t1_ret_a", ret_a, 32'd4);
      check("t1_stall_a", stall_a, 32'd0);
      check("t1_ret_b", ret_b, 32'd1);
      check("t1_stall_b", stall_b, 32'd3);

      // fill under backpressure, then drain
      lat_chk = 0;
      for (int i = 0; i < 6; i++) step(1'b1, 16'h21 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      check("t2_occ_a", occ_a, 3'd4);
      check("t2_in_ready_a", in_ready_a, 1'b0);
      check("t2_stall_a", stall_a, 32'd2);
      idle(3, 1'b0);
      idle(8, 1'b1);
      check("t2_ret_a", ret_a, 32'd8);
      check("t2_ret_b", ret_b, 32'd2);
      check("t2_stall_b", stall_b, 32'd8);

      // continuous offer: multi-cycle instance accepts every STAGES+1 cycles
      lat_chk = 1;
      step(1'b1, 16'(0), 1'b1, 1'b0);
      m1_phase = 1;
      for (int i = 1; i < 22; i++) step(1'b1, 16'($urandom_range(0, 16'hffff)), 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      m1_phase = 0;
      idle(8, 1'b1);
      check("t3_ret_a", ret_a, 32'd30);
      check("t3_ret_b", ret_b, 32'd7);

      // flush with three tokens in flight
      for (int i = 0; i < 3; i++) step(1'b1, 16'h41 + 16'(i), 1'b1, 1'b0);
      step(1'b1, 16'h4f, 1'b1, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t4_occ_a", occ_a, 3'd0);
      check("t4_occ_b", occ_b, 3'd0);
      check("t4_ret_a", ret_a, 32'd30);
      step(1'b1, 16'h55, 1'b1, 1'b0);
      idle(8, 1'b1);
      check("t4_ret_a_after", ret_a, 32'd31);

      // asynchronous reset between edges mid-burst
      step(1'b1, 16'h61, 1'b1, 1'b0);
      step(1'b1, 16'h62, 1'b1, 1'b0);
      step(1'b1, 16'h63, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("t5_out_valid_a", out_valid_a, 1'b0);
      check("t5_occ_a", occ_a, 3'd0);
      check("t5_ret_a", ret_a, 32'd0);
      check("t5_stall_a", stall_a, 32'd0);
      check("t5_occ_b", occ_b, 3'd0);
      check("t5_ret_b", ret_b, 32'd0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_in_ready_a", in_ready_a, 1'b1);
      step(1'b1, 16'h66, 1'b1, 1'b0);
      idle(8, 1'b1);
      check("t5_ret_a_after", ret_a, 32'd1);

      // narrow counters saturate
      pulse_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 16'h100 + 16'(i), 1'b1, 1'b0);
      idle(8, 1'b1);
      check("t6_ret_a", ret_a, 32'd20);
      check("t6_ret_c", ret_c, 4'd15);
      idle(3, 1'b1);
      check("t6_ret_c_hold", ret_c, 4'd15);

      // random traffic with occasional flush
      lat_chk = 0;
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hffff)),
              1'($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      idle(12, 1'b1);
      check("end_qa_empty", qa.size(), 0);
      check("end_qb_empty", qb.size(), 0);
      check("end_occ_a", occ_a, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
